// File: rtl/m_serial_subtractor_pkg.sv
// rtl/m_serial_subtractor_pkg.sv - shared state encoding and default width for the serial subtractor
package m_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_N = 4;

endpackage

// File: rtl/m_serial_subtractor_if.sv
// rtl/m_serial_subtractor_if.sv - start/done operand and result bundle for the serial subtractor
interface m_serial_subtractor_if #(
  parameter int N = 4
);

  logic         w_start;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic         r_busy;
  logic         r_done;
  logic [N-1:0] r_d;
  logic         r_borrow;
  logic         r_ovf;

  modport master (
    output w_start, w_a, w_b,
    input  r_busy, r_done, r_d, r_borrow, r_ovf
  );

  modport slave (
    input  w_start, w_a, w_b,
    output r_busy, r_done, r_d, r_borrow, r_ovf
  );

endinterface

// File: rtl/m_FA.sv
// rtl/m_FA.sv - one-bit full-adder cell
module m_FA (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/m_serial_subtractor.sv
// rtl/m_serial_subtractor.sv - bit-serial A - B, LSB first, one full-adder cell with B inverted and carry-in 1
module m_serial_subtractor
  import m_serial_subtractor_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = 3
) (
  input  logic                         w_clk,
  input  logic                         w_rst,
  m_serial_subtractor_if.slave         bus
);

  state_t         state;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   sh;
  logic           c;
  logic [CW-1:0]  cnt;
  logic           a_msb;
  logic           b_msb;
  logic           fa_s;
  logic           fa_co;

  m_FA u_fa (
    .a  (sa[0]),
    .b  (~sb[0]),
    .ci (c),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state        <= ST_IDLE;
      sa           <= '0;
      sb           <= '0;
      sh           <= '0;
      c            <= 1'b0;
      cnt          <= '0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      bus.r_busy   <= 1'b0;
      bus.r_done   <= 1'b0;
      bus.r_d      <= '0;
      bus.r_borrow <= 1'b0;
      bus.r_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          c   <= fa_co;
          sh  <= {fa_s, sh[N-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          // Last bit: publish straight from the cell so r_d never shows a partial word
          if (cnt == CW'(N-1)) begin
            state        <= ST_DONE;
            bus.r_busy   <= 1'b0;
            bus.r_done   <= 1'b1;
            bus.r_d      <= {fa_s, sh[N-1:1]};
            bus.r_borrow <= ~fa_co;
            bus.r_ovf    <= (a_msb != b_msb) && (fa_s != a_msb);
          end
        end
        default: begin
          bus.r_done <= 1'b0;
          // IDLE and DONE both accept a new operation, giving back-to-back issue
          if (bus.w_start) begin
            state      <= ST_RUN;
            sa         <= bus.w_a;
            sb         <= bus.w_b;
            a_msb      <= bus.w_a[N-1];
            b_msb      <= bus.w_b[N-1];
            c          <= 1'b1;
            cnt        <= '0;
            bus.r_busy <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_serial_subtractor.sv
// tb/tb_m_serial_subtractor.sv - directed and exhaustive self-checking bench for m_serial_subtractor
module tb_m_serial_subtractor;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  m_serial_subtractor_if #(.N(N)) bus ();

  m_serial_subtractor #(.N(N), .CW(3)) dut (
    .w_clk (clk),
    .w_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [3:0] d, input logic bo, input logic ov);
    chk({tag, "_done"},   32'(bus.r_done),   32'd1);
    chk({tag, "_busy0"},  32'(bus.r_busy),   32'd0);
    chk({tag, "_d"},      32'(bus.r_d),      32'(d));
    chk({tag, "_borrow"}, 32'(bus.r_borrow), 32'(bo));
    chk({tag, "_ovf"},    32'(bus.r_ovf),    32'(ov));
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic bo, input logic ov);
    bus.w_start = 1'b1;
    bus.w_a = a;
    bus.w_b = b;
    tick();
    bus.w_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk({tag, "_busy"}, 32'(bus.r_busy), 32'd1);
      chk({tag, "_nodone"}, 32'(bus.r_done), 32'd0);
      tick();
    end
    chk_result(tag, d, bo, ov);
    tick();
    chk({tag, "_pulse"}, 32'(bus.r_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    int w;
    int sa_i, sb_i, df;
    logic [3:0] ea, eb;

    bus.w_start = 1'b0;
    bus.w_a = '0;
    bus.w_b = '0;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy",   32'(bus.r_busy),   32'd0);
    chk("rst_done",   32'(bus.r_done),   32'd0);
    chk("rst_d",      32'(bus.r_d),      32'd0);
    chk("rst_borrow", 32'(bus.r_borrow), 32'd0);
    chk("rst_ovf",    32'(bus.r_ovf),    32'd0);
    rst = 1'b0;

    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.r_done) seen++;
    end
    chk("idle_no_done", 32'(seen), 32'd0);

    run_op("op_9m3", 4'd9, 4'd3, 4'd6,  1'b0, 1'b1);
    chk("hold_d", 32'(bus.r_d), 32'd6);
    run_op("op_3m4", 4'd3, 4'd4, 4'd15, 1'b1, 1'b0);
    run_op("op_8m1", 4'd8, 4'd1, 4'd7,  1'b0, 1'b1);

    // Start held high: accept 1-9, operands change during RUN, accept 5-5 at DONE
    bus.w_start = 1'b1;
    bus.w_a = 4'd1;
    bus.w_b = 4'd9;
    tick();
    bus.w_a = 4'd5;
    bus.w_b = 4'd5;
    for (int i = 0; i < N; i++) begin
      chk("b2b1_busy", 32'(bus.r_busy), 32'd1);
      tick();
    end
    chk_result("b2b1", 4'd8, 1'b1, 1'b1);
    tick();
    bus.w_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("b2b2_busy", 32'(bus.r_busy), 32'd1);
      tick();
    end
    chk_result("b2b2", 4'd0, 1'b0, 1'b0);
    tick();

    // Reset during the second RUN cycle of 12-7
    bus.w_start = 1'b1;
    bus.w_a = 4'd12;
    bus.w_b = 4'd7;
    tick();
    bus.w_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",   32'(bus.r_busy),   32'd0);
    chk("abort_done",   32'(bus.r_done),   32'd0);
    chk("abort_d",      32'(bus.r_d),      32'd0);
    chk("abort_borrow", 32'(bus.r_borrow), 32'd0);
    chk("abort_ovf",    32'(bus.r_ovf),    32'd0);
    seen = 0;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      if (bus.r_done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op("op_12m7", 4'd12, 4'd7, 4'd5, 1'b0, 1'b1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ea = 4'(a);
        eb = 4'(b);
        sa_i = (a >= 8) ? a - 16 : a;
        sb_i = (b >= 8) ? b - 16 : b;
        df = sa_i - sb_i;
        bus.w_start = 1'b1;
        bus.w_a = ea;
        bus.w_b = eb;
        tick();
        bus.w_start = 1'b0;
        w = 0;
        while (!bus.r_done && w < 20) begin
          tick();
          w++;
        end
        chk("sweep_done", 32'(bus.r_done), 32'd1);
        chk("sweep_d",      32'(bus.r_d),      32'((a - b) & 15));
        chk("sweep_borrow", 32'(bus.r_borrow), 32'(a < b));
        chk("sweep_ovf",    32'(bus.r_ovf),    32'((df > 7) || (df < -8)));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
